// File: rtl/d_to_sr_driver.sv
// Write-side driver giving a bank of SR cells D-register semantics (target -> Set/Reset excitation, settle, verify).
// Optional SR_DRV_RETRY_EN: a failed check triggers one re-drive before the error is reported.
module d_to_sr_driver #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] sr_S,
    output logic [WIDTH-1:0] sr_R,
    input  logic [WIDTH-1:0] sr_Q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    input  logic             err_clr
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, CHECK} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   target;
    logic [WIDTH-1:0]   drive_tgt;
    logic [WIDTH-1:0]   exc_s, exc_r;
    logic [WIDTH-1:0]   mismatch;
    logic               accept;
    logic               load;
    logic               redrive;
    logic               set_err;
    logic               noop_done;

    function automatic logic [WIDTH-1:0] set_excite(input logic [WIDTH-1:0] t,
                                                    input logic [WIDTH-1:0] q);
        return t & ~q;
    endfunction

    function automatic logic [WIDTH-1:0] reset_excite(input logic [WIDTH-1:0] t,
                                                      input logic [WIDTH-1:0] q);
        return ~t & q;
    endfunction

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = wr_valid & wr_ready;

    // In IDLE the excitation comes from the incoming word; on a re-drive from the latched target.
    assign drive_tgt = (state == IDLE) ? wr_data : target;
    assign exc_s     = set_excite(drive_tgt, sr_Q);
    assign exc_r     = reset_excite(drive_tgt, sr_Q);
    assign mismatch  = sr_Q ^ target;

`ifdef SR_DRV_RETRY_EN
    logic retried;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retried <= 1'b0;
        end else if (state == IDLE) begin
            retried <= 1'b0;
        end else if (redrive) begin
            retried <= 1'b1;
        end
    end

    assign redrive = (state == CHECK) && (mismatch != '0) && !retried;
`else
    assign redrive = 1'b0;
`endif

    assign set_err = (state == CHECK) && !redrive && (mismatch != '0);
    assign done    = noop_done | ((state == CHECK) && !redrive);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (wr_data != sr_Q)) begin
                    state_nxt = DRIVE;
                    load      = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                if (redrive) begin
                    state_nxt = DRIVE;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Excitation is registered and dropped on the last DRIVE edge so RELEASE sees both low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_S      <= '0;
            sr_R      <= '0;
            cnt       <= '0;
            noop_done <= 1'b0;
        end else begin
            noop_done <= accept && (wr_data == sr_Q);
            if (load) begin
                sr_S <= exc_s;
                sr_R <= exc_r;
                cnt  <= CNT_W'(SETTLE_CYC);
            end else if (state == DRIVE) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    sr_S <= '0;
                    sr_R <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            target <= wr_data;
        end
    end

    // A mismatch recorded in the same cycle as err_clr replaces the old mask rather than merging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            err_mask <= '0;
        end else if (set_err) begin
            err      <= 1'b1;
            err_mask <= (err_clr ? '0 : err_mask) | mismatch;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_mask <= '0;
        end
    end

endmodule
